// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-mode clock divider.
// Holds the FSM state type, default half-period table and the table lookup helper.
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int MAX_MODES = 16;
  localparam int MAX_CNT_W = 64;

  // Entry i sits at bits [i*CNT_W +: CNT_W]; mode 0 is the slowest output.
  localparam logic [4*CNT_W_DEF-1:0] HALF_TABLE_DEF =
    {32'd1562500, 32'd3125000, 32'd6250000, 32'd12500000};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef logic [MAX_MODES-1:0][MAX_CNT_W-1:0] wide_table_t;

  // A zero half-period cannot be counted, so it behaves as the fastest setting.
  function automatic logic [MAX_CNT_W-1:0] table_lookup(input wide_table_t tbl,
                                                        input logic [3:0]  idx);
    logic [MAX_CNT_W-1:0] h;
    h = tbl[idx];
    return (h == '0) ? MAX_CNT_W'(1) : h;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Loadable half-period counter: counts 0..limit-1 while running and flags the wrap.
// The limit only changes on load, so a new half-period never truncates the current one.
module clk_div_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  assign wrap = run && (cnt_q == lim_q - ONE);

  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
    end
    if (load) begin
      lim_d = load_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= ONE;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-mode 50% duty clock divider with glitch-free mode switching, clean stop-low and Tick.
// Define CLK_DIV_RUNTIME_DIV_EN to make the half-period table a writable register file.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int                         CNT_W      = CNT_W_DEF,
  parameter int                         NUM_MODES  = 4,
  parameter int                         MODE_W     = 2,
  parameter logic [NUM_MODES*CNT_W-1:0] HALF_TABLE = HALF_TABLE_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic [MODE_W-1:0] Mode,
`ifdef CLK_DIV_RUNTIME_DIV_EN
  input  logic              Div_Wr,
  input  logic [MODE_W-1:0] Div_Idx,
  input  logic [CNT_W-1:0]  Div_Val,
`endif
  output logic              Clk_O,
  output logic              Tick,
  output logic [MODE_W-1:0] Active_Mode,
  output logic              Mode_Err
);

  state_t            state_q, state_d;
  logic              clk_o_q, clk_o_d;
  logic              tick_q, tick_d;
  logic [MODE_W-1:0] active_q, active_d;
  logic [MODE_W-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_err_q, mode_err_d;

  logic              mode_valid;
  logic [MODE_W-1:0] req_pend;
  logic              req_v;
  logic              cnt_run, cnt_clr, cnt_load, wrap;
  logic [CNT_W-1:0]  h_load;
  logic [CNT_W-1:0]  tbl_d [NUM_MODES];
  wide_table_t       tbl_wide;

`ifdef CLK_DIV_RUNTIME_DIV_EN
  logic [CNT_W-1:0] tbl_q [NUM_MODES];

  always_comb begin
    for (int i = 0; i < NUM_MODES; i++) begin
      tbl_d[i] = tbl_q[i];
      if (Div_Wr && (int'(Div_Idx) == i)) begin
        tbl_d[i] = Div_Val;
      end
    end
  end

  // NOTE: this small table must power up holding HALF_TABLE, so unlike a RAM it is reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_MODES; i++) begin
        tbl_q[i] <= HALF_TABLE[i*CNT_W +: CNT_W];
      end
    end else begin
      for (int i = 0; i < NUM_MODES; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_MODES; i++) begin
      tbl_d[i] = HALF_TABLE[i*CNT_W +: CNT_W];
    end
  end
`endif

  // Lookup reads the next-state table so a write landing on a boundary is picked up there.
  always_comb begin
    tbl_wide = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      tbl_wide[i] = MAX_CNT_W'(tbl_d[i]);
    end
  end

  assign h_load = CNT_W'(table_lookup(tbl_wide, 4'(active_d)));

  assign mode_valid = int'(mode_q) < NUM_MODES;
  assign mode_d     = Mode;
  assign mode_err_d = !mode_valid;

  // Latest valid request wins; asking for the active mode cancels any pending switch.
  always_comb begin
    req_pend = pend_q;
    req_v    = pend_v_q;
    if (mode_valid) begin
      if (mode_q != active_q) begin
        req_pend = mode_q;
        req_v    = 1'b1;
      end else begin
        req_v    = 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    clk_o_d  = clk_o_q;
    tick_d   = 1'b0;
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_run  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_o_d  = 1'b0;
        pend_v_d = 1'b0;
        cnt_clr  = 1'b1;
        cnt_load = 1'b1;
        if (En) begin
          state_d = RUN;
          if (mode_valid) begin
            active_d = mode_q;
          end
        end
      end

      RUN, DRAIN: begin
        cnt_run  = 1'b1;
        pend_d   = req_pend;
        pend_v_d = req_v;
        if (wrap) begin
          cnt_load = 1'b1;
          if (req_v) begin
            active_d = req_pend;
            pend_v_d = 1'b0;
          end
          if (En) begin
            clk_o_d = !clk_o_q;
            tick_d  = !clk_o_q;
            state_d = RUN;
          end else begin
            // Stopping always lands low, whichever phase the boundary ends.
            clk_o_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = En ? RUN : DRAIN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      clk_o_q    <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      mode_q     <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_o_q    <= clk_o_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      mode_q     <= mode_d;
      mode_err_q <= mode_err_d;
    end
  end

  clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .run      (cnt_run),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (h_load),
    .wrap     (wrap)
  );

  assign Clk_O       = clk_o_q;
  assign Tick        = tick_q;
  assign Active_Mode = active_q;
  assign Mode_Err    = mode_err_q;

endmodule
